// File: rtl/dpa_time_keeper_if.sv
// Load/pause controls and time outputs of the real-time clock stage.
// The slave modport is the time keeper; the master is its driver/observer.
interface dpa_time_keeper_if;
    logic        load_en;
    logic [23:0] load_time;
    logic        pause;
    logic [23:0] curr_time;
    logic        sec_tick;
    logic [5:0]  digit_chg;
    logic        day_wrap;
    logic        time_valid;
    logic        load_err;

    modport slave (
        input  load_en, load_time, pause,
        output curr_time, sec_tick, digit_chg, day_wrap, time_valid, load_err
    );

    modport master (
        output load_en, load_time, pause,
        input  curr_time, sec_tick, digit_chg, day_wrap, time_valid, load_err
    );
endinterface

// File: rtl/dpa_time_keeper.sv
// BCD hh:mm:ss real-time clock advanced once per TICK_CYCLES clocks, with
// software load, pause and per-digit change flags.
//   state | meaning
//   UNSET | no valid time loaded yet, prescaler held at 0
//   RUN   | prescaler counting, time advances on terminal count
//   PAUSE | prescaler frozen, no ticks
module dpa_time_keeper #(
    parameter int TICK_CYCLES = 1000000,
    parameter int PS_W        = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    dpa_time_keeper_if.slave     tk
);
    typedef enum logic [1:0] {UNSET, RUN, PAUSE} state_t;

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_CYCLES - 1);

    state_t          state_q, state_d;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [23:0]     time_q, time_d;
    logic            tick_q, tick_d;
    logic [5:0]      chg_q, chg_d;
    logic            wrap_q, wrap_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [23:0]     time_inc;

    function automatic logic bcd_ok(input logic [23:0] t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 6; i++)
            if (t[4*i +: 4] > 4'd9) ok = 1'b0;
        if (t[7:0] > 8'h59 || t[15:8] > 8'h59 || t[23:16] > 8'h23) ok = 1'b0;
        return ok;
    endfunction

    // One-second BCD increment; each digit rolls only when all lower digits roll.
    function automatic logic [23:0] bcd_inc(input logic [23:0] t);
        logic [23:0] n;
        n = t;
        if (t[3:0] != 4'd9) n[3:0] = t[3:0] + 4'd1;
        else begin
            n[3:0] = 4'd0;
            if (t[7:4] != 4'd5) n[7:4] = t[7:4] + 4'd1;
            else begin
                n[7:4] = 4'd0;
                if (t[11:8] != 4'd9) n[11:8] = t[11:8] + 4'd1;
                else begin
                    n[11:8] = 4'd0;
                    if (t[15:12] != 4'd5) n[15:12] = t[15:12] + 4'd1;
                    else begin
                        n[15:12] = 4'd0;
                        if (t[23:16] == 8'h23) n[23:16] = 8'h00;
                        else if (t[19:16] == 4'd9) begin
                            n[19:16] = 4'd0;
                            n[23:20] = t[23:20] + 4'd1;
                        end else n[19:16] = t[19:16] + 4'd1;
                    end
                end
            end
        end
        return n;
    endfunction

    assign time_inc = bcd_inc(time_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= UNSET;
            ps_q    <= '0;
            time_q  <= '0;
            tick_q  <= 1'b0;
            chg_q   <= '0;
            wrap_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            time_q  <= time_d;
            tick_q  <= tick_d;
            chg_q   <= chg_d;
            wrap_q  <= wrap_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        time_d  = time_q;
        tick_d  = 1'b0;
        chg_d   = '0;
        wrap_d  = 1'b0;
        valid_d = valid_q;
        err_d   = err_q;
        if (tk.load_en) begin
            // A load pre-empts any tick due this cycle.
            if (bcd_ok(tk.load_time)) begin
                time_d  = tk.load_time;
                ps_d    = '0;
                valid_d = 1'b1;
                err_d   = 1'b0;
                chg_d   = 6'h3F;
                state_d = tk.pause ? PAUSE : RUN;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                UNSET: ps_d = '0;
                RUN: begin
                    if (ps_q == PS_LAST) begin
                        ps_d   = '0;
                        time_d = time_inc;
                        tick_d = 1'b1;
                        wrap_d = (time_inc == 24'h0);
                        for (int i = 0; i < 6; i++)
                            chg_d[i] = (time_inc[4*i +: 4] != time_q[4*i +: 4]);
                    end else begin
                        ps_d = ps_q + 1'b1;
                    end
                    if (tk.pause) state_d = PAUSE;
                end
                PAUSE: if (!tk.pause) state_d = RUN;
                default: state_d = UNSET;
            endcase
        end
    end

    assign tk.curr_time  = time_q;
    assign tk.sec_tick   = tick_q;
    assign tk.digit_chg  = chg_q;
    assign tk.day_wrap   = wrap_q;
    assign tk.time_valid = valid_q;
    assign tk.load_err   = err_q;
endmodule
